// File: rtl/data_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_ctrl_pkg
// Description : Shared pipeline definitions for the MEM-stage data memory:
//               default data/address widths and the controller state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package data_ram_ctrl_pkg;

  localparam int C_DW_DEFAULT = 8;
  localparam int C_AW_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/data_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_ctrl_if
// Description : Bus bundle for the data memory controller: pipeline write
//               port, handshaked loader write port and read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_ram_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 8
);

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  // Requester side: pipeline, loader and reader
  modport master (
    output mem_we, mem_waddr, mem_wdata,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    output rd_addr,
    input  rd_data
  );

  // Controller side
  modport slave (
    input  mem_we, mem_waddr, mem_wdata,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    input  rd_addr,
    output rd_data
  );

endinterface
`default_nettype wire

// File: rtl/data_ram_ctrl_dram_array.sv
`default_nettype none
// ============================================================================
// Module      : dram_array
// Description : Plain DEPTH x DW storage array, one synchronous write port
//               and one asynchronous read port. No reset, so it can map onto
//               block or distributed RAM. Callers keep addresses in range.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_array #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_ctrl
// Description : MEM-stage data memory controller. Arbitrates the storage
//               write port between the clear sequencer, the pipeline and the
//               loader, tracks dropped writes and accepted loader writes, and
//               provides a combinational or registered (forwarding) read.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int DW       = C_DW_DEFAULT,
  parameter int AW       = C_AW_DEFAULT,
  parameter int DEPTH    = 2**AW,
  parameter int READ_REG = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          drop_err,
  output logic [AW:0]   ld_count,
  data_ram_ctrl_if.slave bus
);

  localparam logic [AW-1:0] C_LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_MAX  = '1;

  // Addresses at or beyond DEPTH have no storage behind them
  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < C_DEPTH);
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_clr_start;
  logic [AW-1:0] r_ptr;
  logic          r_drop_err;
  logic [AW:0]   r_ld_count;
  logic          w_ld_xfer;

  logic          w_arr_we;
  logic [AW-1:0] w_arr_waddr;
  logic [DW-1:0] w_arr_wdata;
  logic [DW-1:0] w_arr_rdata;
  logic [DW-1:0] w_rd_arr;
  logic [DW-1:0] w_rd_out;

  assign busy          = (r_state == ST_CLEAR);
  assign bus.ld_ready  = !busy && !bus.mem_we;
  assign w_ld_xfer     = bus.ld_valid && bus.ld_ready;
  assign drop_err      = r_drop_err;
  assign ld_count      = r_ld_count;

  // Next-state logic: clear runs to the last word, clr_req only honoured when idle
  always_comb begin
    w_state_nxt = r_state;
    w_clr_start = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (r_ptr == C_LAST_PTR) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_clr_start = 1'b1;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // State register and clear pointer; reset restarts the clear from word 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_start) begin
        r_ptr <= '0;
      end else if (busy) begin
        r_ptr <= (r_ptr == C_LAST_PTR) ? '0 : r_ptr + AW'(1);
      end
    end
  end

  // Write-port mux: clear > pipeline > loader; out-of-range writes are swallowed
  always_comb begin
    w_arr_we    = 1'b0;
    w_arr_waddr = bus.mem_waddr;
    w_arr_wdata = bus.mem_wdata;
    if (busy) begin
      w_arr_we    = 1'b1;
      w_arr_waddr = r_ptr;
      w_arr_wdata = '0;
    end else if (bus.mem_we) begin
      w_arr_we    = in_range(bus.mem_waddr);
    end else if (w_ld_xfer) begin
      w_arr_we    = in_range(bus.ld_addr);
      w_arr_waddr = bus.ld_addr;
      w_arr_wdata = bus.ld_data;
    end
  end

  // Sticky drop flag and saturating loader counter; a clear request zeroes the
  // counter even if a loader transfer lands in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_err <= 1'b0;
      r_ld_count <= '0;
    end else begin
      if (busy && bus.mem_we) begin
        r_drop_err <= 1'b1;
      end
      if (w_clr_start) begin
        r_ld_count <= '0;
      end else if (w_ld_xfer && (r_ld_count != C_CNT_MAX)) begin
        r_ld_count <= r_ld_count + (AW+1)'(1);
      end
    end
  end

  dram_array #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .waddr (w_arr_waddr),
    .wdata (w_arr_wdata),
    .raddr (bus.rd_addr),
    .rdata (w_arr_rdata)
  );

  assign w_rd_arr = in_range(bus.rd_addr) ? w_arr_rdata : '0;

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [DW-1:0] r_rd_data;

      // Registered read; a same-edge write to the read address is forwarded
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rd_data <= '0;
        end else if (busy) begin
          r_rd_data <= '0;
        end else if (w_arr_we && (w_arr_waddr == bus.rd_addr)) begin
          r_rd_data <= w_arr_wdata;
        end else begin
          r_rd_data <= w_rd_arr;
        end
      end

      assign w_rd_out = r_rd_data;
    end else begin : g_read_comb
      assign w_rd_out = w_rd_arr;
    end
  endgenerate

  // Contents are meaningless while the clear is in flight
  assign bus.rd_data = busy ? '0 : w_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_ctrl
// Description : Directed self-checking bench. Instance A: DEPTH=256 with a
//               combinational read. Instance B: DEPTH=200 with a registered,
//               forwarding read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_a, busy_a, drop_a;
  logic [8:0] cnt_a;
  logic       clr_b, busy_b, drop_b;
  logic [8:0] cnt_b;

  int n_checks = 0;
  int n_err    = 0;
  int n, na, nb;

  data_ram_ctrl_if #(.DW(8), .AW(8)) ifa ();
  data_ram_ctrl_if #(.DW(8), .AW(8)) ifb ();

  data_ram_ctrl #(.DW(8), .AW(8), .DEPTH(256), .READ_REG(0)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_a),
    .busy     (busy_a),
    .drop_err (drop_a),
    .ld_count (cnt_a),
    .bus      (ifa)
  );

  data_ram_ctrl #(.DW(8), .AW(8), .DEPTH(200), .READ_REG(1)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_b),
    .busy     (busy_b),
    .drop_err (drop_b),
    .ld_count (cnt_b),
    .bus      (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    ifa.mem_we = 1'b0; ifa.mem_waddr = '0; ifa.mem_wdata = '0;
    ifa.ld_valid = 1'b0; ifa.ld_addr = '0; ifa.ld_data = '0; ifa.rd_addr = '0;
    ifb.mem_we = 1'b0; ifb.mem_waddr = '0; ifb.mem_wdata = '0;
    ifb.ld_valid = 1'b0; ifb.ld_addr = '0; ifb.ld_data = '0; ifb.rd_addr = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_busy_a", busy_a, 1);
    check("rst_busy_b", busy_b, 1);
    check("rst_drop_a", drop_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_rd_a", ifa.rd_data, 0);
    check("rst_rd_b", ifb.rd_data, 0);

    // ---- release reset, measure both clear lengths ----
    @(negedge clk); rst = 1'b1;
    n = 0; na = 0; nb = 0;
    while ((busy_a || busy_b) && n < 1000) begin
      @(posedge clk); #1; n++;
      if (!busy_a && na == 0) na = n;
      if (!busy_b && nb == 0) nb = n;
    end
    check("clear_len_a", na, 256);
    check("clear_len_b", nb, 200);

    @(negedge clk);
    ifa.rd_addr = 8'h00; #1 check("idle_rd_00", ifa.rd_data, 0);
    ifa.rd_addr = 8'h7F; #1 check("idle_rd_7f", ifa.rd_data, 0);
    ifa.rd_addr = 8'hFF; #1 check("idle_rd_ff", ifa.rd_data, 0);

    // ---- arbitration: pipeline beats loader on the same address ----
    @(negedge clk);
    ifa.mem_we = 1'b1; ifa.mem_waddr = 8'h10; ifa.mem_wdata = 8'hAA;
    ifa.ld_valid = 1'b1; ifa.ld_addr = 8'h10; ifa.ld_data = 8'h55;
    ifa.rd_addr = 8'h10;
    #1;
    check("arb_ld_ready_blocked", ifa.ld_ready, 0);
    check("arb_rd_before", ifa.rd_data, 0);
    @(negedge clk);
    check("arb_pipe_wr", ifa.rd_data, 8'hAA);
    ifa.mem_we = 1'b0;
    #1 check("arb_ld_ready", ifa.ld_ready, 1);
    @(negedge clk);
    ifa.ld_valid = 1'b0;
    #1;
    check("arb_ld_wr", ifa.rd_data, 8'h55);
    check("arb_ld_count", cnt_a, 1);

    // ---- pipeline write dropped during a requested clear ----
    @(negedge clk); clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    #1;
    check("clr_busy", busy_a, 1);
    check("clr_cnt_zero", cnt_a, 0);
    check("clr_rd_forced0", ifa.rd_data, 0);
    @(negedge clk);
    ifa.mem_we = 1'b1; ifa.mem_waddr = 8'h20; ifa.mem_wdata = 8'h77;
    @(negedge clk);
    ifa.mem_we = 1'b0;
    #1 check("drop_err_set", drop_a, 1);
    n = 0;
    while (busy_a && n < 1000) begin @(posedge clk); #1; n++; end
    check("clr_done_a", busy_a, 0);
    @(negedge clk);
    ifa.rd_addr = 8'h20; #1 check("drop_mem20", ifa.rd_data, 0);
    ifa.rd_addr = 8'h10; #1 check("clr_mem10", ifa.rd_data, 0);

    // ---- second clear request: exact length, drop flag survives ----
    @(negedge clk); clr_a = 1'b1;
    @(posedge clk); #1; clr_a = 1'b0;
    n = 0;
    while (busy_a && n < 1000) begin @(posedge clk); #1; n++; end
    check("clr_len_req", n, 256);
    check("drop_err_hold", drop_a, 1);

    // ---- reset in the middle of a clear ----
    @(negedge clk);
    ifa.ld_valid = 1'b1; ifa.ld_addr = 8'h05; ifa.ld_data = 8'h33;
    @(negedge clk);
    ifa.ld_valid = 1'b0;
    #1 check("ld_count_pre", cnt_a, 1);
    clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b0; clr_a = 1'b1;
    #1;
    check("midrst_drop_clr", drop_a, 0);
    check("midrst_cnt", cnt_a, 0);
    check("midrst_busy", busy_a, 1);
    @(negedge clk); rst = 1'b1; clr_a = 1'b0;
    n = 0;
    while (busy_a && n < 1000) begin @(posedge clk); #1; n++; end
    check("midrst_len", n, 256);
    check("midrst_cnt_after", cnt_a, 0);
    @(negedge clk);
    ifa.rd_addr = 8'h05; #1 check("midrst_mem05", ifa.rd_data, 0);

    // ---- pipeline write and clear request in the same idle cycle ----
    @(negedge clk);
    ifa.mem_we = 1'b1; ifa.mem_waddr = 8'h40; ifa.mem_wdata = 8'h9C;
    clr_a = 1'b1; ifa.rd_addr = 8'h40;
    @(negedge clk);
    ifa.mem_we = 1'b0; clr_a = 1'b0;
    #1;
    check("same_busy", busy_a, 1);
    check("same_no_drop", drop_a, 0);

    // ---- instance B: forwarding and registered-read latency ----
    @(negedge clk);
    ifb.rd_addr = 8'h30;
    ifb.mem_we = 1'b1; ifb.mem_waddr = 8'h30; ifb.mem_wdata = 8'h3C;
    #1 check("fwd_before", ifb.rd_data, 0);
    @(negedge clk);
    ifb.mem_we = 1'b0;
    #1 check("fwd_hit", ifb.rd_data, 8'h3C);
    ifb.rd_addr = 8'h31;
    #1 check("rdreg_hold", ifb.rd_data, 8'h3C);
    @(negedge clk); #1 check("rdreg_next", ifb.rd_data, 0);
    ifb.rd_addr = 8'h30;
    @(negedge clk); #1 check("rdreg_mem30", ifb.rd_data, 8'h3C);

    // ---- instance B: out-of-range loader write ----
    ifb.ld_valid = 1'b1; ifb.ld_addr = 8'hF0; ifb.ld_data = 8'hEE;
    ifb.rd_addr = 8'hF0;
    #1 check("oor_ld_ready", ifb.ld_ready, 1);
    @(negedge clk);
    ifb.ld_valid = 1'b0;
    #1;
    check("oor_ld_count", cnt_b, 1);
    check("oor_rd", ifb.rd_data, 0);
    ifb.rd_addr = 8'h70;
    @(negedge clk); #1 check("oor_alias70", ifb.rd_data, 0);

    // ---- instance B: last valid word vs first invalid word ----
    ifb.mem_we = 1'b1; ifb.mem_waddr = 8'hC7; ifb.mem_wdata = 8'h5A;
    ifb.rd_addr = 8'hC7;
    @(negedge clk);
    ifb.mem_waddr = 8'hC8; ifb.mem_wdata = 8'h11; ifb.rd_addr = 8'hC8;
    #1 check("last_valid_fwd", ifb.rd_data, 8'h5A);
    @(negedge clk);
    ifb.mem_we = 1'b0;
    #1 check("first_invalid", ifb.rd_data, 0);
    ifb.rd_addr = 8'h48;
    @(negedge clk); #1 check("first_invalid_alias", ifb.rd_data, 0);
    ifb.rd_addr = 8'hC7;
    @(negedge clk); #1 check("last_valid_mem", ifb.rd_data, 8'h5A);

    // ---- instance B: loader counter saturation ----
    ifb.ld_valid = 1'b1; ifb.ld_addr = 8'hF5; ifb.ld_data = 8'h01;
    repeat (520) @(negedge clk);
    ifb.ld_valid = 1'b0;
    #1 check("ld_count_sat", cnt_b, 511);

    // ---- instance A: clear started alongside the write wiped it ----
    n = 0;
    while (busy_a && n < 1000) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    ifa.rd_addr = 8'h40; #1 check("same_mem40_cleared", ifa.rd_data, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
